// File: rtl/tb_core_data_demux.sv
// tb_core_data_demux
//   Routes the core's OBI-style data port (req/gnt/rvalid) to one of four
//   targets: HWPE peripheral port, stack memory, TCDM port, or a local MMIO
//   block that holds the exit code and a putchar register.
//
//   A small in-order FIFO records the target of each granted request. The
//   core response is taken only from the target at the FIFO head. A response
//   from any other target, or a response while the FIFO is empty, is dropped
//   and sets a sticky error flag.
//
// Ports
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   core_*                      core data port (req/gnt/rvalid, we, be, addr, wdata, rdata)
//   periph_*, stack_*, tcdm_*   target ports (req/gnt, wen=1 for read, add/be/data,
//                               r_data/r_valid)
//   exit_valid_o, exit_code_o   sticky exit flag and the last word written to MMIO_BASE+0x0
//   putc_valid_o, putc_char_o   one-cycle pulse and byte for each write to MMIO_BASE+0x4
//   resp_err_o                  sticky out-of-order or unexpected response flag
module tb_core_data_demux #(
  parameter int unsigned HWPE_ADDR_BASE_BIT = 20,
  parameter int unsigned MAX_OUTSTANDING    = 2,
  parameter logic [7:0]  MMIO_BASE          = 8'h80
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        core_req_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic [31:0] core_rdata_o,

  output logic        periph_req_o,
  input  logic        periph_gnt_i,
  output logic        periph_wen_o,
  output logic [31:0] periph_add_o,
  output logic [3:0]  periph_be_o,
  output logic [31:0] periph_data_o,
  input  logic [31:0] periph_r_data_i,
  input  logic        periph_r_valid_i,

  output logic        stack_req_o,
  input  logic        stack_gnt_i,
  output logic        stack_wen_o,
  output logic [31:0] stack_add_o,
  output logic [3:0]  stack_be_o,
  output logic [31:0] stack_data_o,
  input  logic [31:0] stack_r_data_i,
  input  logic        stack_r_valid_i,

  output logic        tcdm_req_o,
  input  logic        tcdm_gnt_i,
  output logic        tcdm_wen_o,
  output logic [31:0] tcdm_add_o,
  output logic [3:0]  tcdm_be_o,
  output logic [31:0] tcdm_data_o,
  input  logic [31:0] tcdm_r_data_i,
  input  logic        tcdm_r_valid_i,

  output logic        exit_valid_o,
  output logic [31:0] exit_code_o,
  output logic        putc_valid_o,
  output logic [7:0]  putc_char_o,
  output logic        resp_err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  // Storage is rounded up to a power of two so that any pointer value is a
  // legal index. The pointers still wrap at MAX_OUTSTANDING.
  localparam int unsigned DEPTH = 2 ** PTR_W;

  localparam logic [1:0] TGT_PERIPH = 2'd0;
  localparam logic [1:0] TGT_STACK  = 2'd1;
  localparam logic [1:0] TGT_TCDM   = 2'd2;
  localparam logic [1:0] TGT_MMIO   = 2'd3;

  logic [1:0]       fifo_tgt  [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;

  logic [1:0]  sel_tgt;
  logic        sel_gnt;
  logic        full;
  logic        req_ok;
  logic        push, pop;
  logic        head_valid;
  logic [1:0]  head_tgt;
  logic        head_rvalid;
  logic [31:0] head_rdata;
  logic        err_set;
  logic        mmio_off0, mmio_off4;
  logic        mmio_acc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Address decode. MMIO wins over the HWPE bit.
  always_comb begin
    sel_tgt = TGT_TCDM;
    if (core_addr_i[31:24] == MMIO_BASE)          sel_tgt = TGT_MMIO;
    else if (core_addr_i[HWPE_ADDR_BASE_BIT])     sel_tgt = TGT_PERIPH;
    else if (core_addr_i[31:24] == 8'h00)         sel_tgt = TGT_STACK;
  end

  always_comb begin
    sel_gnt = 1'b1;
    case (sel_tgt)
      TGT_PERIPH: sel_gnt = periph_gnt_i;
      TGT_STACK:  sel_gnt = stack_gnt_i;
      TGT_TCDM:   sel_gnt = tcdm_gnt_i;
      default:    sel_gnt = 1'b1;
    endcase
  end

  assign full   = (count_q == CNT_W'(MAX_OUTSTANDING));
  // rst_ni gates the combinational outputs so that req and gnt drop as soon
  // as reset is asserted, not only at the next clock edge.
  assign req_ok = rst_ni & core_req_i & ~full;

  assign periph_req_o = req_ok & (sel_tgt == TGT_PERIPH);
  assign stack_req_o  = req_ok & (sel_tgt == TGT_STACK);
  assign tcdm_req_o   = req_ok & (sel_tgt == TGT_TCDM);

  assign periph_wen_o  = ~core_we_i;
  assign periph_add_o  = core_addr_i;
  assign periph_be_o   = core_be_i;
  assign periph_data_o = core_wdata_i;
  assign stack_wen_o   = ~core_we_i;
  assign stack_add_o   = core_addr_i;
  assign stack_be_o    = core_be_i;
  assign stack_data_o  = core_wdata_i;
  assign tcdm_wen_o    = ~core_we_i;
  assign tcdm_add_o    = core_addr_i;
  assign tcdm_be_o     = core_be_i;
  assign tcdm_data_o   = core_wdata_i;

  assign core_gnt_o = rst_ni & ~full & sel_gnt;
  assign push       = core_req_i & core_gnt_o;

  assign mmio_off0 = (core_addr_i[23:0] == 24'h00_0000);
  assign mmio_off4 = (core_addr_i[23:0] == 24'h00_0004);
  assign mmio_acc  = push & (sel_tgt == TGT_MMIO);

  assign head_valid = (count_q != '0);
  assign head_tgt   = fifo_tgt[rptr_q];

  always_comb begin
    head_rvalid = 1'b0;
    head_rdata  = '0;
    case (head_tgt)
      TGT_PERIPH: begin head_rvalid = periph_r_valid_i; head_rdata = periph_r_data_i; end
      TGT_STACK:  begin head_rvalid = stack_r_valid_i;  head_rdata = stack_r_data_i;  end
      TGT_TCDM:   begin head_rvalid = tcdm_r_valid_i;   head_rdata = tcdm_r_data_i;   end
      default:    begin head_rvalid = 1'b1;             head_rdata = fifo_data[rptr_q]; end
    endcase
  end

  assign core_rvalid_o = head_valid & head_rvalid;
  assign core_rdata_o  = core_rvalid_o ? head_rdata : '0;
  assign pop           = core_rvalid_o;

  // A target response is legal only when that target sits at the FIFO head.
  assign err_set =
      (periph_r_valid_i & ~(head_valid & (head_tgt == TGT_PERIPH))) |
      (stack_r_valid_i  & ~(head_valid & (head_tgt == TGT_STACK)))  |
      (tcdm_r_valid_i   & ~(head_valid & (head_tgt == TGT_TCDM)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_tgt[i]  <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_tgt[wptr_q]  <= sel_tgt;
        fifo_data[wptr_q] <= (~core_we_i & mmio_off0) ? exit_code_o : '0;
        wptr_q            <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exit_valid_o <= 1'b0;
      exit_code_o  <= '0;
      putc_valid_o <= 1'b0;
      putc_char_o  <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      if (mmio_acc && core_we_i && mmio_off0) begin
        exit_valid_o <= 1'b1;
        exit_code_o  <= core_wdata_i;
      end
      putc_valid_o <= mmio_acc & core_we_i & mmio_off4;
      if (mmio_acc && core_we_i && mmio_off4) putc_char_o <= core_wdata_i[7:0];
      if (err_set) resp_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tb_core_data_demux.sv
module tb_tb_core_data_demux;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_gnt_o, core_rvalid_o, core_we_i;
  logic [3:0]  core_be_i;
  logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
  logic        periph_req_o, periph_gnt_i, periph_wen_o, periph_r_valid_i;
  logic [31:0] periph_add_o, periph_data_o, periph_r_data_i;
  logic [3:0]  periph_be_o;
  logic        stack_req_o, stack_gnt_i, stack_wen_o, stack_r_valid_i;
  logic [31:0] stack_add_o, stack_data_o, stack_r_data_i;
  logic [3:0]  stack_be_o;
  logic        tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
  logic [31:0] tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
  logic [3:0]  tcdm_be_o;
  logic        exit_valid_o, putc_valid_o, resp_err_o;
  logic [31:0] exit_code_o;
  logic [7:0]  putc_char_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  tb_core_data_demux #(
    .HWPE_ADDR_BASE_BIT(20),
    .MAX_OUTSTANDING(2),
    .MMIO_BASE(8'h80)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .core_we_i(core_we_i), .core_be_i(core_be_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o),
    .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i), .periph_wen_o(periph_wen_o),
    .periph_add_o(periph_add_o), .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
    .periph_r_data_i(periph_r_data_i), .periph_r_valid_i(periph_r_valid_i),
    .stack_req_o(stack_req_o), .stack_gnt_i(stack_gnt_i), .stack_wen_o(stack_wen_o),
    .stack_add_o(stack_add_o), .stack_be_o(stack_be_o), .stack_data_o(stack_data_o),
    .stack_r_data_i(stack_r_data_i), .stack_r_valid_i(stack_r_valid_i),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_add_o(tcdm_add_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .exit_valid_o(exit_valid_o), .exit_code_o(exit_code_o),
    .putc_valid_o(putc_valid_o), .putc_char_o(putc_char_o), .resp_err_o(resp_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks run 1 ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    core_req_i   = 1'b1;
    core_addr_i  = addr;
    core_we_i    = we;
    core_wdata_i = wdata;
  endtask

  initial begin
    rst_ni = 1'b0;
    core_req_i = 0; core_we_i = 0; core_be_i = 4'hF; core_addr_i = '0; core_wdata_i = '0;
    periph_gnt_i = 0; periph_r_valid_i = 0; periph_r_data_i = '0;
    stack_gnt_i = 0;  stack_r_valid_i = 0;  stack_r_data_i = '0;
    tcdm_gnt_i = 0;   tcdm_r_valid_i = 0;   tcdm_r_data_i = '0;

    // Reset state
    #3;
    chk("rst_gnt", core_gnt_o, 0);
    chk("rst_rvalid", core_rvalid_o, 0);
    chk("rst_exit_valid", exit_valid_o, 0);
    chk("rst_resp_err", resp_err_o, 0);
    tick();
    rst_ni = 1'b1;

    // 1: stack read, response one cycle after grant
    stack_gnt_i = 1;
    req(32'h0000_1000, 1'b0, '0);
    #1;
    chk("t1_gnt", core_gnt_o, 1);
    chk("t1_stack_req", stack_req_o, 1);
    chk("t1_stack_wen", stack_wen_o, 1);
    chk("t1_periph_req", periph_req_o, 0);
    chk("t1_tcdm_req", tcdm_req_o, 0);
    tick();
    core_req_i = 0;
    stack_r_valid_i = 1; stack_r_data_i = 32'hCAFE_0001;
    #1;
    chk("t1_rvalid", core_rvalid_o, 1);
    chk("t1_rdata", core_rdata_o, 32'hCAFE_0001);
    tick();
    stack_r_valid_i = 0;
    #1;
    chk("t1_rvalid_done", core_rvalid_o, 0);

    // 2: MMIO exit code and putchar
    req(32'h8000_0000, 1'b1, 32'h0);
    #1;
    chk("t2_mmio_gnt", core_gnt_o, 1);
    chk("t2_no_stack_req", stack_req_o, 0);
    chk("t2_no_tcdm_req", tcdm_req_o, 0);
    chk("t2_no_periph_req", periph_req_o, 0);
    tick();
    core_req_i = 0;
    #1;
    chk("t2_exit_valid", exit_valid_o, 1);
    chk("t2_exit_code0", exit_code_o, 0);
    chk("t2_wr_rvalid", core_rvalid_o, 1);
    chk("t2_no_putc", putc_valid_o, 0);
    tick();
    req(32'h8000_0000, 1'b0, '0);
    tick();
    core_req_i = 0;
    #1;
    chk("t2_rd_rvalid", core_rvalid_o, 1);
    chk("t2_rd_data0", core_rdata_o, 0);
    tick();
    req(32'h8000_0000, 1'b1, 32'h1234_5678);
    tick();
    core_req_i = 0;
    #1;
    chk("t2_exit_code", exit_code_o, 32'h1234_5678);
    tick();
    req(32'h8000_0000, 1'b0, '0);
    tick();
    core_req_i = 0;
    #1;
    chk("t2_rd_exit", core_rdata_o, 32'h1234_5678);
    tick();
    req(32'h8000_0008, 1'b0, '0);
    tick();
    core_req_i = 0;
    #1;
    chk("t2_rd_other_v", core_rvalid_o, 1);
    chk("t2_rd_other_d", core_rdata_o, 0);
    tick();
    req(32'h8000_0004, 1'b1, 32'h0000_AB41);
    tick();
    core_req_i = 0;
    #1;
    chk("t2_putc_valid", putc_valid_o, 1);
    chk("t2_putc_char", putc_char_o, 8'h41);
    chk("t2_exit_keep", exit_code_o, 32'h1234_5678);
    tick();
    chk("t2_putc_pulse", putc_valid_o, 0);

    // 3: TCDM reads, three-cycle latency, FIFO depth two
    tcdm_gnt_i = 1;
    req(32'h1001_0000, 1'b0, '0);
    #1;
    chk("t3_gnt_a", core_gnt_o, 1);
    tick();
    core_addr_i = 32'h1001_0004;
    #1;
    chk("t3_gnt_b", core_gnt_o, 1);
    tick();
    core_addr_i = 32'h1001_0008;
    #1;
    chk("t3_full_gnt", core_gnt_o, 0);
    chk("t3_full_req", tcdm_req_o, 0);
    tick();
    tcdm_r_valid_i = 1; tcdm_r_data_i = 32'hD000_0001;
    #1;
    chk("t3_rv1", core_rvalid_o, 1);
    chk("t3_rd1", core_rdata_o, 32'hD000_0001);
    chk("t3_full_pop_gnt", core_gnt_o, 0);
    tick();
    tcdm_r_data_i = 32'hD000_0002;
    #1;
    chk("t3_rv2", core_rvalid_o, 1);
    chk("t3_rd2", core_rdata_o, 32'hD000_0002);
    chk("t3_gnt_c", core_gnt_o, 1);
    tick();
    core_req_i = 0; tcdm_r_valid_i = 0;
    #1;
    chk("t3_idle1", core_rvalid_o, 0);
    tick();
    chk("t3_idle2", core_rvalid_o, 0);
    tick();
    tcdm_r_valid_i = 1; tcdm_r_data_i = 32'hD000_0003;
    #1;
    chk("t3_rv3", core_rvalid_o, 1);
    chk("t3_rd3", core_rdata_o, 32'hD000_0003);
    tick();
    tcdm_r_valid_i = 0;
    #1;
    chk("t3_empty", core_rvalid_o, 0);
    chk("t3_no_err", resp_err_o, 0);

    // 4: decode priority (combinational, no clock edge while requesting)
    periph_gnt_i = 1;
    req(32'h1C10_0000, 1'b1, 32'h5555_AAAA);
    #1;
    chk("t4_periph_req", periph_req_o, 1);
    chk("t4_periph_wen_w", periph_wen_o, 0);
    chk("t4_periph_add", periph_add_o, 32'h1C10_0000);
    chk("t4_periph_data", periph_data_o, 32'h5555_AAAA);
    chk("t4_tcdm_off", tcdm_req_o, 0);
    core_we_i = 0;
    #1;
    chk("t4_periph_wen_r", periph_wen_o, 1);
    core_addr_i = 32'h1C01_0000;
    #1;
    chk("t4_tcdm_req", tcdm_req_o, 1);
    chk("t4_periph_off", periph_req_o, 0);
    core_addr_i = 32'h8010_0000;
    #1;
    chk("t4_mmio_prio_p", periph_req_o, 0);
    chk("t4_mmio_prio_t", tcdm_req_o, 0);
    chk("t4_mmio_gnt", core_gnt_o, 1);
    core_addr_i = 32'h1C10_0000; periph_gnt_i = 0;
    #1;
    chk("t4_periph_nogt", core_gnt_o, 0);
    core_req_i = 0;
    tick();

    // 5: stray stack response while TCDM is at the head
    req(32'h1001_0000, 1'b0, '0);
    tick();
    core_req_i = 0;
    stack_r_valid_i = 1; stack_r_data_i = 32'hBAD0_0000;
    #1;
    chk("t5_ignored", core_rvalid_o, 0);
    tick();
    stack_r_valid_i = 0;
    #1;
    chk("t5_err_set", resp_err_o, 1);
    tcdm_r_valid_i = 1; tcdm_r_data_i = 32'hD000_0005;
    #1;
    chk("t5_head_rd", core_rdata_o, 32'hD000_0005);
    tick();
    tcdm_r_valid_i = 0;
    #1;
    chk("t5_err_sticky", resp_err_o, 1);

    // 6: reset with two stack reads in flight
    req(32'h0000_2000, 1'b0, '0);
    tick();
    core_addr_i = 32'h0000_2004;
    tick();
    rst_ni = 0;
    stack_r_valid_i = 1; stack_r_data_i = 32'h7777_7777;
    #1;
    chk("t6_gnt", core_gnt_o, 0);
    chk("t6_stack_req", stack_req_o, 0);
    chk("t6_rvalid", core_rvalid_o, 0);
    chk("t6_rdata", core_rdata_o, 0);
    chk("t6_exit_valid", exit_valid_o, 0);
    chk("t6_exit_code", exit_code_o, 0);
    chk("t6_putc", putc_valid_o, 0);
    chk("t6_resp_err", resp_err_o, 0);
    core_req_i = 0; stack_r_valid_i = 0;
    tick();
    rst_ni = 1;
    #1;
    chk("t6_empty_after", core_gnt_o, 1);
    req(32'h0000_3000, 1'b0, '0);
    tick();
    core_req_i = 0;
    stack_r_valid_i = 1; stack_r_data_i = 32'h0BAD_F00D;
    #1;
    chk("t6_fresh_rv", core_rvalid_o, 1);
    chk("t6_fresh_rd", core_rdata_o, 32'h0BAD_F00D);
    tick();
    chk("t6_no_err", resp_err_o, 0);
    // The FIFO is now empty, so this response is unexpected.
    tick();
    chk("t6_stale_err", resp_err_o, 1);
    stack_r_valid_i = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
